countdown_ctrl: RTL
===================

# countdown_ctrl

Countdown-timer control core, directly downstream of the switch debouncers. Consumes their single-cycle key pulses (increment with auto-repeat, start/stop, clear) and a 1 Hz enable tick. Holds the BCD MM:SS value and runs the IDLE/RUN/PAUSE/ALARM state machine. Its registered outputs drive the display multiplexer and the alarm/beeper logic.

## Interface
- MAX_MIN, 99: highest settable minute value, decimal, 1..99; stored in BCD.
- ALARM_TICKS, 10: number of CE_1HZ ticks ALARM stays asserted before the automatic return to IDLE; 1..255.
- CLK  in  1  system clock; all state updates on rising edge.
- CLR_N  in  1  asynchronous active-low reset.
- CE_1HZ  in  1  one-cycle pulse once per second.
- KEY_MIN  in  1  one-cycle pulse: increment minutes (debouncer KEY_UP, repeat enabled).
- KEY_SEC  in  1  one-cycle pulse: increment seconds (debouncer KEY_UP, repeat enabled).
- KEY_SS  in  1  one-cycle pulse: start/stop.
- KEY_CLR  in  1  one-cycle pulse: clear.
- MIN_BCD  out  8  minutes, two BCD digits, tens digit in [7:4].
- SEC_BCD  out  8  seconds, two BCD digits, tens digit in [7:4].
- STATE  out  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- RUNNING  out  1  high when STATE==RUN.
- ALARM  out  1  high when STATE==ALARM.

## Operation
- Internal registers: time (MIN/SEC BCD), setpoint (MIN/SEC BCD), state, and an 8-bit alarm tick counter.
- Reset (CLR_N low, asynchronous) sets time = setpoint = 00:00, STATE = IDLE, RUNNING = 0, ALARM = 0, and the alarm counter to 0.
- Input priority within one cycle: KEY_CLR > KEY_SS > KEY_MIN/KEY_SEC > CE_1HZ. A lower-priority input arriving in the same cycle as a higher one is discarded, not deferred.

IDLE
- KEY_MIN: minutes +1 in BCD. MAX_MIN wraps to 00.
- KEY_SEC: seconds +1 in BCD. 59 wraps to 00, with no carry into minutes.
- KEY_MIN and KEY_SEC in the same cycle: both apply.
- KEY_SS with time != 00:00: setpoint <= time, then go to RUN. KEY_SS with time == 00:00 is ignored.
- KEY_CLR: time = setpoint = 00:00.
- CE_1HZ is ignored.

RUN
- On CE_1HZ, decrement time by one second:
  - seconds != 00: seconds -1. A units digit of 0 becomes 9 and the tens digit decrements.
  - seconds == 00 and minutes != 00: minutes -1 (BCD) and seconds = 59.
  - If the new value is 00:00, the state becomes ALARM on the same edge.
- KEY_SS: go to PAUSE.
- KEY_CLR: go to IDLE with time = setpoint = 00:00.
- KEY_MIN and KEY_SEC are ignored.

PAUSE
- Time is frozen and CE_1HZ, KEY_MIN and KEY_SEC are ignored.
- KEY_SS: return to RUN.
- KEY_CLR: go to IDLE with time = setpoint = 00:00.

ALARM
- Entry clears the alarm counter. Each CE_1HZ increments it.
- When the counter reaches ALARM_TICKS: go to IDLE with time <= setpoint, so the same countdown can be restarted immediately.
- KEY_SS: go to IDLE immediately with time <= setpoint.
- KEY_CLR: go to IDLE with time = setpoint = 00:00.
- KEY_MIN and KEY_SEC are ignored.

General rules
- The BCD digits of time and setpoint are never outside 0..9, and seconds never exceed 59.
- Asserting CLR_N low in any state returns to the reset values immediately, independent of CLK.

## Timing
- All outputs are registered. A key or tick sampled at edge n shows its effect on the outputs from edge n onward, i.e. one-cycle latency from pulse to output.
- RUNNING, ALARM and STATE change on the same edge as the state register.
- The 00:00 transition and the ALARM assertion happen on the same edge as the final CE_1HZ.
- The first decrement after KEY_SS occurs on the next CE_1HZ after entering RUN. The prescaler phase is not reset.
- Back-to-back pulses on consecutive cycles are each processed, e.g. two KEY_MIN pulses give +2.
- Reset release is synchronous to CLK in the surrounding design. The block does not resynchronise CLR_N.

## Test plan
- Reset then hold: CLR_N low mid-RUN at 01:30 -> outputs go immediately to 00:00, STATE=0, RUNNING=0, ALARM=0; KEY_SS at 00:00 afterwards -> STATE stays 0.
- Setting wrap: from 00:00 apply 100 KEY_MIN pulses -> MIN_BCD=8'h00 (wraps after 8'h99); apply 61 KEY_SEC pulses -> SEC_BCD=8'h01, MIN_BCD unchanged.
- Countdown borrow: set 01:00, KEY_SS, one CE_1HZ -> 00:59 (MIN_BCD=8'h00, SEC_BCD=8'h59); nine more ticks -> SEC_BCD=8'h50 via 8'h51.
- Alarm flow: set 00:02, KEY_SS, two ticks -> ALARM=1 and STATE=3 on the second tick edge; ALARM_TICKS further ticks -> STATE=0 and time restored to 00:02.
- Pause and priority: in RUN at 00:10, KEY_SS and CE_1HZ in the same cycle -> STATE=2, time stays 00:10; ticks in PAUSE -> no change; KEY_SS -> RUN resumes from 00:10.
- Clear priority: in RUN, KEY_CLR and KEY_SS in the same cycle -> STATE=0, time 00:00; in ALARM, KEY_SS -> IDLE with the setpoint reloaded.

Source files
------------

// File: rtl/countdown_ctrl.sv
// Countdown-timer control core: BCD MM:SS time/setpoint registers and the
// IDLE/RUN/PAUSE/ALARM state machine driven by debounced key pulses and a 1 Hz tick.
module countdown_ctrl #(
  parameter int unsigned MAX_MIN     = 99,
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       CE_1HZ,
  input  logic       KEY_MIN,
  input  logic       KEY_SEC,
  input  logic       KEY_SS,
  input  logic       KEY_CLR,
  output logic [7:0] MIN_BCD,
  output logic [7:0] SEC_BCD,
  output logic [1:0] STATE,
  output logic       RUNNING,
  output logic       ALARM
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam logic [7:0] MIN_TOP   = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] SEC_TOP   = 8'h59;
  localparam logic [7:0] TICKS_END = 8'(ALARM_TICKS);

  state_t     state_q, state_d;
  logic [7:0] min_q, min_d, sec_q, sec_d;
  logic [7:0] spm_q, spm_d, sps_q, sps_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dec_min, dec_sec;
  logic       run_d, alm_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      return '0;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      spm_q   <= '0;
      sps_q   <= '0;
      cnt_q   <= '0;
      RUNNING <= 1'b0;
      ALARM   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      spm_q   <= spm_d;
      sps_q   <= sps_d;
      cnt_q   <= cnt_d;
      RUNNING <= run_d;
      ALARM   <= alm_d;
    end
  end

  // Priority CLR > SS > MIN/SEC > CE; losing inputs in a cycle are dropped.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    spm_d   = spm_q;
    sps_d   = sps_q;
    cnt_d   = cnt_q;
    dec_min = min_q;
    dec_sec = sec_q;
    if (KEY_CLR) begin
      state_d = S_IDLE;
      min_d   = '0;
      sec_d   = '0;
      spm_d   = '0;
      sps_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (KEY_SS) begin
            if ((min_q != '0) || (sec_q != '0)) begin
              spm_d   = min_q;
              sps_d   = sec_q;
              state_d = S_RUN;
            end
          end else begin
            if (KEY_MIN) min_d = bcd_inc(min_q, MIN_TOP);
            if (KEY_SEC) sec_d = bcd_inc(sec_q, SEC_TOP);
          end
        end
        S_RUN: begin
          if (KEY_SS) begin
            state_d = S_PAUSE;
          end else if (CE_1HZ) begin
            if (sec_q != '0) begin
              dec_sec = bcd_dec(sec_q);
            end else if (min_q != '0) begin
              dec_min = bcd_dec(min_q);
              dec_sec = SEC_TOP;
            end
            min_d = dec_min;
            sec_d = dec_sec;
            if ((dec_min == '0) && (dec_sec == '0)) begin
              state_d = S_ALARM;
              cnt_d   = '0;
            end
          end
        end
        S_PAUSE: begin
          if (KEY_SS) state_d = S_RUN;
        end
        S_ALARM: begin
          if (KEY_SS) begin
            state_d = S_IDLE;
            min_d   = spm_q;
            sec_d   = sps_q;
          end else if (CE_1HZ) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == TICKS_END) begin
              state_d = S_IDLE;
              min_d   = spm_q;
              sec_d   = sps_q;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    run_d = (state_d == S_RUN);
    alm_d = (state_d == S_ALARM);
  end

  assign MIN_BCD = min_q;
  assign SEC_BCD = sec_q;
  assign STATE   = state_q;

endmodule
